// File: rtl/deconv_col_collector.sv
// Overlap-add collector for transposed-convolution columns: partial columns are summed into a
// WEIGHT_SIZE-deep ring of accumulators, and each output column is streamed out once it is complete.
module deconv_col_collector #(
  parameter  int BIT_WIDTH      = 8,
  parameter  int WEIGHT_SIZE    = 5,
  parameter  int FEATURE_SIZE   = 8,
  parameter  int STRIDE_SETTING = 2,
  localparam int N_PIX_OUT = FEATURE_SIZE*WEIGHT_SIZE - (WEIGHT_SIZE-STRIDE_SETTING)*(FEATURE_SIZE-1),
  localparam int PW        = 2*BIT_WIDTH,
  localparam int CW        = PW*N_PIX_OUT,
  localparam int IW        = (N_PIX_OUT > 1) ? $clog2(N_PIX_OUT) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_col_valid,
  output logic          o_col_ready,
  input  logic [CW-1:0] i_cmpl_deconv_col,
  input  logic          i_clear,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_out_col,
  output logic [IW-1:0] o_out_idx,
  output logic          o_last,
  output logic          o_done,
  output logic          o_busy
);

  localparam int SW = (WEIGHT_SIZE > 1) ? $clog2(WEIGHT_SIZE) : 1;
  localparam int KW = SW;
  localparam int JW = (FEATURE_SIZE > 1) ? $clog2(FEATURE_SIZE) : 1;
  localparam int EW = $clog2(WEIGHT_SIZE + 1);
  localparam logic [IW-1:0] S_IW = IW'(STRIDE_SETTING);

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FLUSH, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] slot_q [WEIGHT_SIZE];
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;
  logic [IW-1:0] base_q;      // j*S, first output position owed by the current j
  logic [SW-1:0] bslot_q;     // (j*S) mod WEIGHT_SIZE
  logic [SW-1:0] wr_q;
  logic [SW-1:0] rd_q;
  logic [IW-1:0] out_idx_q;
  logic [EW-1:0] em_q;
  logic          valid_q;
  logic          col_ready, busy, done;
  logic          accept, fire, last_k, last_j, em_last;

  function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] a, input int inc);
    int s;
    s = int'(a) + inc;
    if (s >= WEIGHT_SIZE) s = s - WEIGHT_SIZE;
    return SW'(s);
  endfunction

  assign accept  = i_col_valid && col_ready;
  assign fire    = valid_q && i_ready;
  assign last_k  = (k_q == KW'(WEIGHT_SIZE-1));
  assign last_j  = (j_q == JW'(FEATURE_SIZE-1));
  assign em_last = (em_q == EW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    col_ready = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (i_clear) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          col_ready = 1'b1;
          if (i_col_valid) state_n = last_k ? (last_j ? FLUSH : DRAIN) : ACCUM;
        end
        DRAIN:   if (fire && em_last) state_n = ACCUM;
        FLUSH:   if (fire && em_last) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clear) begin
      for (int w = 0; w < WEIGHT_SIZE; w++) slot_q[w] <= '0;
      j_q       <= '0;
      k_q       <= '0;
      base_q    <= '0;
      bslot_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      out_idx_q <= '0;
      em_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_PIX_OUT; i++)
          slot_q[wr_q][i*PW +: PW] <= slot_q[wr_q][i*PW +: PW] + i_cmpl_deconv_col[i*PW +: PW];
        if (last_k) begin
          k_q       <= '0;
          rd_q      <= bslot_q;
          out_idx_q <= base_q;
          em_q      <= last_j ? EW'(WEIGHT_SIZE) : EW'(STRIDE_SETTING);
          if (last_j) begin
            j_q     <= '0;
            base_q  <= '0;
            bslot_q <= '0;
            wr_q    <= '0;
          end else begin
            j_q     <= j_q + 1'b1;
            base_q  <= base_q + S_IW;
            bslot_q <= slot_add(bslot_q, STRIDE_SETTING);
            wr_q    <= slot_add(bslot_q, STRIDE_SETTING);
          end
        end else begin
          k_q  <= k_q + 1'b1;
          wr_q <= slot_add(wr_q, 1);
        end
      end
      // Accepts and emissions never coincide: ready is only offered while nothing is being emitted.
      if (fire) begin
        slot_q[rd_q] <= '0;
        rd_q         <= slot_add(rd_q, 1);
        out_idx_q    <= out_idx_q + 1'b1;
        em_q         <= em_q - 1'b1;
      end
      valid_q <= (state_n == DRAIN) || (state_n == FLUSH);
    end
  end

  assign o_col_ready = col_ready;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_valid     = valid_q;
  assign o_out_idx   = out_idx_q;
  assign o_out_col   = valid_q ? slot_q[rd_q] : '0;
  assign o_last      = valid_q && (out_idx_q == IW'(N_PIX_OUT-1));

endmodule

// File: tb/tb_deconv_col_collector.sv
// Directed bench for deconv_col_collector: a full-length overlap-add model fills a scoreboard queue,
// which is drained and compared as the DUT emits columns.
module tb_deconv_col_collector;
  localparam int W    = 5;
  localparam int F    = 8;
  localparam int S    = 2;
  localparam int N    = 19;
  localparam int PW   = 16;
  localparam int CW   = PW*N;
  localparam int IW   = 5;
  localparam int NCOL = F*W;

  logic          i_clk = 1'b0;
  logic          i_rst, i_col_valid, o_col_ready, i_clear, o_valid, i_ready, o_last, o_done, o_busy;
  logic [CW-1:0] i_cmpl_deconv_col, o_out_col;
  logic [IW-1:0] o_out_idx;

  always #5 i_clk = ~i_clk;

  deconv_col_collector #(
    .BIT_WIDTH(8), .WEIGHT_SIZE(W), .FEATURE_SIZE(F), .STRIDE_SETTING(S)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_col_valid(i_col_valid), .o_col_ready(o_col_ready),
    .i_cmpl_deconv_col(i_cmpl_deconv_col), .i_clear(i_clear), .o_valid(o_valid),
    .i_ready(i_ready), .o_out_col(o_out_col), .o_out_idx(o_out_idx), .o_last(o_last),
    .o_done(o_done), .o_busy(o_busy)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [CW-1:0] col;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] chan [NCOL];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt;
  bit            acc_now, done_pend, done_seen, hold_v, stall_chk, quiet_chk;
  logic [IW-1:0] hold_idx;
  logic [CW-1:0] hold_col;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    acc_now = i_col_valid && o_col_ready;
    if (acc_now) acc_cnt++;
    if (o_col_ready) chk("ready_excl_valid", CW'(o_valid), CW'(0));
    chk("done_pulse", CW'(o_done), CW'(done_pend));
    if (done_pend && o_done === 1'b1) done_seen = 1;
    done_pend = 0;
    if (stall_chk) begin
      chk("stall_valid", CW'(o_valid), CW'(1));
      chk("stall_idx", CW'(o_out_idx), CW'(0));
      chk("stall_ready", CW'(o_col_ready), CW'(0));
    end
    if (quiet_chk) begin
      chk("clear_valid", CW'(o_valid), CW'(0));
      chk("clear_busy", CW'(o_busy), CW'(0));
    end
    if (o_valid === 1'b1) begin
      if (hold_v) begin
        chk("hold_idx", CW'(o_out_idx), CW'(hold_idx));
        chk("hold_col", o_out_col, hold_col);
      end
      if (i_ready) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL extra_column observed idx=%0d expected none", o_out_idx);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("col_idx", CW'(o_out_idx), CW'(e.idx));
          chk("col_data", o_out_col, e.col);
          chk("col_last", CW'(o_last), CW'(e.last));
          if (e.last) done_pend = 1;
        end
        hold_v = 0;
      end else begin
        hold_v   = 1;
        hold_idx = o_out_idx;
        hold_col = o_out_col;
      end
    end else begin
      hold_v = 0;
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #2;
  endtask

  task automatic drive_col(input logic [CW-1:0] d);
    int n = 0;
    i_col_valid       = 1'b1;
    i_cmpl_deconv_col = d;
    do begin
      tick();
      n++;
    end while (!acc_now && n < 300);
    checks++;
    assert (acc_now) else begin
      errors++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic drive_cols(input int first, input int count);
    for (int i = first; i < first + count; i++) drive_col(chan[i]);
    i_col_valid = 1'b0;
  endtask

  // Reference model: accumulate into the full-length output, not a ring.
  task automatic build_expect();
    logic [PW-1:0] acc [N][N];
    exp_t e;
    for (int p = 0; p < N; p++)
      for (int x = 0; x < N; x++) acc[p][x] = '0;
    for (int j = 0; j < F; j++)
      for (int k = 0; k < W; k++)
        for (int x = 0; x < N; x++)
          acc[j*S+k][x] = acc[j*S+k][x] + chan[j*W+k][x*PW +: PW];
    for (int p = 0; p < N; p++) begin
      e.idx  = IW'(p);
      e.last = (p == N-1);
      for (int x = 0; x < N; x++) e.col[x*PW +: PW] = acc[p][x];
      sb.push_back(e);
    end
  endtask

  task automatic start_channel();
    acc_cnt   = 0;
    done_seen = 0;
    build_expect();
  endtask

  task automatic finish_channel();
    int n = 0;
    while (!done_seen && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen", CW'(done_seen), CW'(1));
    chk("sb_empty", CW'(sb.size()), CW'(0));
    chk("accepts", CW'(acc_cnt), CW'(NCOL));
  endtask

  task automatic full_channel();
    start_channel();
    drive_cols(0, NCOL);
    finish_channel();
  endtask

  task automatic reset_pulse();
    i_rst       = 1'b1;
    i_col_valid = 1'b0;
    @(negedge i_clk);
    chk("rst_col_ready", CW'(o_col_ready), CW'(1));
    chk("rst_valid", CW'(o_valid), CW'(0));
    chk("rst_out_col", o_out_col, CW'(0));
    chk("rst_out_idx", CW'(o_out_idx), CW'(0));
    chk("rst_last", CW'(o_last), CW'(0));
    chk("rst_done", CW'(o_done), CW'(0));
    chk("rst_busy", CW'(o_busy), CW'(0));
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    sb.delete();
    hold_v    = 0;
    done_pend = 0;
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int c = 0; c < NCOL; c++)
      for (int x = 0; x < N; x++) chan[c][x*PW +: PW] = v;
  endtask

  task automatic fill_rand();
    for (int c = 0; c < NCOL; c++)
      for (int x = 0; x < N; x++) chan[c][x*PW +: PW] = PW'($urandom);
  endtask

  initial begin
    i_rst = 1'b1; i_col_valid = 1'b0; i_cmpl_deconv_col = '0; i_clear = 1'b0; i_ready = 1'b1;
    acc_now = 0; done_pend = 0; done_seen = 0; hold_v = 0; stall_chk = 0; quiet_chk = 0;
    acc_cnt = 0; hold_idx = '0; hold_col = '0;
    reset_pulse();

    // all-ones channel, downstream always ready
    fill_const(16'd1);
    full_channel();

    // downstream stalls for 5 cycles on the first drain
    start_channel();
    drive_cols(0, W);
    i_ready   = 1'b0;
    stall_chk = 1;
    repeat (5) tick();
    stall_chk = 0;
    i_ready   = 1'b1;
    drive_cols(W, NCOL - W);
    finish_channel();

    // two 0x8000 contributions to p=2 wrap to zero
    fill_const(16'd0);
    for (int x = 0; x < N; x++) begin
      chan[2][x*PW +: PW] = 16'h8000;
      chan[W][x*PW +: PW] = 16'h8000;
    end
    full_channel();

    // reset during the drain after j=3, then a clean all-ones channel
    fill_rand();
    start_channel();
    drive_cols(0, 4*W);
    chk("pre_reset_valid", CW'(o_valid), CW'(1));
    reset_pulse();
    fill_const(16'd1);
    full_channel();

    // clear at j=2,k=3, then a fresh random channel
    fill_rand();
    start_channel();
    drive_cols(0, 2*W + 3);
    i_clear           = 1'b1;
    i_col_valid       = 1'b1;
    i_cmpl_deconv_col = chan[2*W + 3];
    tick();
    i_clear     = 1'b0;
    i_col_valid = 1'b0;
    sb.delete();
    quiet_chk = 1;
    repeat (3) tick();
    quiet_chk = 0;
    fill_rand();
    full_channel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deconv_col_collector.md
DECONV_COL_COLLECTOR -- requirements
Module: deconv_col_collector

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, input pixel bit width (each deconv column pixel is 2*BIT_WIDTH bits, two's complement).
REQ-002 SHALL have parameter WEIGHT_SIZE, default 5, number of kernel columns per feature column.
REQ-003 SHALL have parameter FEATURE_SIZE, default 8, number of feature-map columns per channel.
REQ-004 SHALL have parameter STRIDE_SETTING, default 2, deconv stride S (1 <= S <= WEIGHT_SIZE).
REQ-005 SHALL derive N_PIX_OUT = FEATURE_SIZE*WEIGHT_SIZE - (WEIGHT_SIZE-S)*(FEATURE_SIZE-1), which is 19 at defaults, and use it as both column height and output column count.
REQ-006 SHALL have port i_clk, input, 1 bit, the single clock; all logic is clocked on the rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port i_col_valid, input, 1 bit, meaning a partial deconv column is present on i_cmpl_deconv_col.
REQ-009 SHALL have port o_col_ready, output, 1 bit, meaning the block accepts a partial column this cycle.
REQ-010 SHALL have port i_cmpl_deconv_col, input, 2*BIT_WIDTH*N_PIX_OUT bits, the partial column, with pixel 0 at the LSBs.
REQ-011 SHALL have port i_clear, input, 1 bit, synchronous abort of the current channel.
REQ-012 SHALL have port o_valid, output, 1 bit, meaning a finished output column is present.
REQ-013 SHALL have port i_ready, input, 1 bit, downstream acceptance.
REQ-014 SHALL have port o_out_col, output, 2*BIT_WIDTH*N_PIX_OUT bits, the finished column.
REQ-015 SHALL have port o_out_idx, output, $clog2(N_PIX_OUT) bits, the output column position p.
REQ-016 SHALL have port o_last, output, 1 bit, high with the column p = N_PIX_OUT-1.
REQ-017 SHALL have port o_done, output, 1 bit, a one-cycle pulse after the last column is accepted.
REQ-018 SHALL have port o_busy, output, 1 bit, high in every state except IDLE.

Function
REQ-019 SHALL receive partial columns in the order feature column j = 0..FEATURE_SIZE-1, and within each j, kernel column k = 0..WEIGHT_SIZE-1; each partial column maps to output position p = j*S + k.
REQ-020 SHALL hold a ring buffer of WEIGHT_SIZE accumulator columns indexed by p mod WEIGHT_SIZE; reset, i_clear and emission of a slot all zero that slot.
REQ-021 SHALL, on each accept (i_col_valid & o_col_ready), set slot[p mod WEIGHT_SIZE] to slot plus input, per pixel, with 2*BIT_WIDTH-bit wrap-around and no saturation.
REQ-022 SHALL implement the states IDLE, ACCUM, DRAIN, FLUSH and DONE.
REQ-023 SHALL move from IDLE to ACCUM on the first i_col_valid, and SHALL accept that column in the same cycle.
REQ-024 SHALL assert o_col_ready only in IDLE and ACCUM, and SHALL never assert o_col_ready while o_valid is high.
REQ-025 SHALL, after accepting k = WEIGHT_SIZE-1 for j < FEATURE_SIZE-1, go to DRAIN and emit positions j*S .. j*S+S-1 in ascending order, then return to ACCUM with j+1 and k = 0.
REQ-026 SHALL, after accepting k = WEIGHT_SIZE-1 for j = FEATURE_SIZE-1, go to FLUSH and emit positions j*S .. N_PIX_OUT-1 (WEIGHT_SIZE columns) in ascending order.
REQ-027 SHALL present o_valid registered, with the first column of a DRAIN or FLUSH appearing on the cycle after the triggering accept; each column advances on o_valid & i_ready, and o_out_col, o_out_idx and o_last hold stable while i_ready is low.
REQ-028 SHALL go to DONE after accepting o_last, pulse o_done for one cycle, then go to IDLE with j and k at 0.
REQ-029 SHALL make i_clear highest priority in any state: next state IDLE, counters 0, buffer zeroed, and no further output; an in-flight o_valid drops on the next cycle.
REQ-030 SHALL ignore i_cmpl_deconv_col when o_col_ready is low.

Reset
REQ-031 SHALL, while i_rst is high, force IDLE, j = k = 0, all buffer slots to 0, and o_col_ready=1, o_valid=0, o_out_col=0, o_out_idx=0, o_last=0, o_done=0, o_busy=0.
REQ-032 SHALL, when reset is asserted mid-DRAIN or mid-FLUSH, discard the channel, and the next channel SHALL start at j = 0 from a zeroed buffer.

Verification
REQ-033 SHALL be verified with all 40 partial columns with every pixel = 1 and i_ready = 1 -> 19 columns, p = 0..18, pixel values per p = 1,1,2,2,3,2,3,2,...,3,2,2,1,1 (p=4 gives 3, p=18 gives 1), o_last at p=18, and o_done one cycle later.
REQ-034 SHALL be verified with i_ready held low for 5 cycles during the first DRAIN -> o_valid stays high, o_out_idx stays 0, o_col_ready stays 0, and no column is lost or duplicated.
REQ-035 SHALL be verified with pixel 0x8000 at j=0,k=2 and j=1,k=0 -> p=2 pixel equals 0x0000 (wrap-around).
REQ-036 SHALL be verified with i_rst pulsed during the DRAIN after j=3 -> all outputs take reset values; a following full channel of ones reproduces the REQ-033 results exactly.
REQ-037 SHALL be verified with i_clear asserted in ACCUM at j=2,k=3 -> IDLE next cycle and no o_valid; the next channel has no residue from the aborted one.
REQ-038 SHALL be verified with i_col_valid held high continuously -> accepts occur only while o_col_ready is high, and there are exactly 40 accepts per channel.
